sram_b_port_arbiter: RTL and testbench

- Shares one 1-write/1-read SRAM macro (4096 x 8, write mask, 12-bit address; write port 0, read port 1, 1-cycle synchronous read) among NREQ requesters.
- Each cycle, issues at most one write on port 0 and one read on port 1, each picked by its own round-robin arbiter.
- Returns read data with a requester tag.
- Resolves same-address write/read collisions, which the macro forbids, and bounds read starvation caused by those collisions.

---
 rtl/sram_b_arb_pkg.sv | 32 +++
 rtl/sram_b_port_arbiter_rr.sv | 33 +++
 rtl/sram_b_port_arbiter.sv | 107 ++++++++++
 tb/tb_sram_b_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_b_arb_pkg.sv
// Shared constants and the round-robin pick helper used by both ports of the
// SRAM B-port arbiter.
package sram_b_arb_pkg;
  localparam int SRAM_ABITS = 12;
  localparam int SRAM_DBITS = 8;
  localparam int MAX_REQ    = 8;

  typedef struct packed {
    logic [MAX_REQ-1:0] oneHot;
    logic [2:0]         idx;
  } rr_pick_t;

  // Scan from pri upward modulo n; the smallest offset with a set mask bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                       input logic [2:0]         pri,
                                       input int                 n);
    rr_pick_t res;
    int       slot;
    res = '0;
    for (int off = MAX_REQ - 1; off >= 0; off--) begin
      if (off < n) begin
        slot = int'(pri) + off;
        if (slot >= n) slot = slot - n;
        if (mask[3'(slot)]) begin
          res.oneHot = MAX_REQ'(1) << slot;
          res.idx    = 3'(slot);
        end
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/sram_b_port_arbiter_rr.sv
// Round-robin arbiter with its own priority pointer; the pointer moves past
// the granted index only when the caller confirms the grant was issued.
module rr_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gntIdx_o,
  output logic          any_o
);
  rr_pick_t      pick;
  logic [IW-1:0] pri_q, pri_d;

  always_comb begin
    pick     = rr_pick(MAX_REQ'(req_i), 3'(pri_q), N);
    gnt_o    = N'(pick.oneHot);
    gntIdx_o = IW'(pick.idx);
    any_o    = |pick.oneHot;
    pri_d    = pri_q;
    if (adv_i) pri_d = (gntIdx_o == IW'(N - 1)) ? '0 : gntIdx_o + IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pri_q <= '0;
    else       pri_q <= pri_d;
  end
endmodule

// File: rtl/sram_b_port_arbiter.sv
// Shares a 1W/1R SRAM among NREQ requesters: one write and one read per cycle,
// with same-address collisions resolved and read starvation bounded.
module sram_b_port_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_STALL = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*SRAM_ABITS-1:0] req_addr,
  input  logic [NREQ*SRAM_DBITS-1:0] req_wdata,
  input  logic [NREQ*SRAM_DBITS-1:0] req_wem,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [SRAM_DBITS-1:0]      rsp_data,
  output logic                       sram_CE0,
  output logic [SRAM_ABITS-1:0]      sram_A0,
  output logic [SRAM_DBITS-1:0]      sram_D0,
  output logic                       sram_WE0,
  output logic [SRAM_DBITS-1:0]      sram_WEM0,
  output logic                       sram_CE1,
  output logic [SRAM_ABITS-1:0]      sram_A1,
  input  logic [SRAM_DBITS-1:0]      sram_Q1
);
  localparam int SW = $clog2(MAX_STALL + 1);

  logic [NREQ-1:0]       wCand, rCand, wGnt, rGnt;
  logic [IDW-1:0]        wIdx, rIdx;
  logic                  wAny, rAny, collide, wIssue, rIssue;
  logic [SRAM_ABITS-1:0] wAddr, rAddr;
  logic [SW-1:0]         stallCnt_q, stallCnt_d;
  logic                  rdPrio_q, rdPrio_d;
  logic                  rspValid_q;
  logic [IDW-1:0]        rspId_q;

  // Masking candidates during reset keeps both ports idle and both pointers parked.
  always_comb begin
    wCand = RST ? '0 : (req_valid & req_we);
    rCand = RST ? '0 : (req_valid & ~req_we);
  end

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_wrArb (
    .clk_i(CLK), .rst_i(RST), .req_i(wCand), .adv_i(wIssue),
    .gnt_o(wGnt), .gntIdx_o(wIdx), .any_o(wAny)
  );

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rdArb (
    .clk_i(CLK), .rst_i(RST), .req_i(rCand), .adv_i(rIssue),
    .gnt_o(rGnt), .gntIdx_o(rIdx), .any_o(rAny)
  );

  always_comb begin
    wAddr   = req_addr[int'(wIdx)*SRAM_ABITS +: SRAM_ABITS];
    rAddr   = req_addr[int'(rIdx)*SRAM_ABITS +: SRAM_ABITS];
    collide = wAny && rAny && (wAddr == rAddr);
    wIssue  = wAny && !(collide && rdPrio_q);
    rIssue  = rAny && !(collide && !rdPrio_q);

    req_ready = (wIssue ? wGnt : '0) | (rIssue ? rGnt : '0);
    sram_CE0  = wIssue;
    sram_WE0  = wIssue;
    sram_A0   = wIssue ? wAddr : '0;
    sram_D0   = wIssue ? req_wdata[int'(wIdx)*SRAM_DBITS +: SRAM_DBITS] : '0;
    sram_WEM0 = wIssue ? req_wem[int'(wIdx)*SRAM_DBITS +: SRAM_DBITS] : '0;
    sram_CE1  = rIssue;
    sram_A1   = rIssue ? rAddr : '0;
  end

  // A read losing to a write counts toward the guard; once it trips, the next
  // collision goes to the read and the guard rearms.
  always_comb begin
    stallCnt_d = stallCnt_q;
    rdPrio_d   = rdPrio_q;
    if (collide && !rdPrio_q) begin
      if (stallCnt_q != SW'(MAX_STALL)) stallCnt_d = stallCnt_q + SW'(1);
      if (stallCnt_d == SW'(MAX_STALL)) rdPrio_d = 1'b1;
    end else if (collide && rdPrio_q) begin
      stallCnt_d = '0;
      rdPrio_d   = 1'b0;
    end else if (rIssue) begin
      stallCnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stallCnt_q <= '0;
      rdPrio_q   <= 1'b0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      rdPrio_q   <= rdPrio_d;
      rspValid_q <= rIssue;
      if (rIssue) rspId_q <= rIdx;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = sram_Q1;
endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Directed bench for sram_b_port_arbiter: a behavioural SRAM model, per-cycle
// port checks, and a scoreboard of expected read responses.
module tb_sram_b_port_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 12;
  localparam int DW   = 8;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NREQ-1:0]      req_valid, req_ready, req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata, req_wem;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 sram_CE0, sram_WE0, sram_CE1;
  logic [AW-1:0]        sram_A0, sram_A1;
  logic [DW-1:0]        sram_D0, sram_WEM0;
  logic [DW-1:0]        sram_Q1 = '0;
  logic [DW-1:0]        mem [0:4095];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } rsp_t;

  rsp_t expQ[$];
  rsp_t monExp;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 CLK = ~CLK;

  sram_b_port_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_STALL(3)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wem(req_wem),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_CE0(sram_CE0), .sram_A0(sram_A0), .sram_D0(sram_D0),
    .sram_WE0(sram_WE0), .sram_WEM0(sram_WEM0),
    .sram_CE1(sram_CE1), .sram_A1(sram_A1), .sram_Q1(sram_Q1)
  );

  // Memory starts with each location holding the low byte of its address.
  initial for (int a = 0; a < 4096; a++) mem[a] = 8'(a);

  always @(posedge CLK) begin
    if (sram_CE1) sram_Q1 <= mem[sram_A1];
    if (sram_CE0 && sram_WE0) mem[sram_A0] <= (mem[sram_A0] & ~sram_WEM0) | (sram_D0 & sram_WEM0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Responses are checked against the scoreboard whenever the DUT presents one.
  always @(negedge CLK) begin
    if (rsp_valid !== 1'b0) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_rsp: got id %0d data 0x%0h, expected no response at %0t",
                 rsp_id, rsp_data, $time);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(monExp.id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(monExp.data));
      end
    end
  end

  task automatic applyStimulus(input int i, input logic v, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_wem[i*DW +: DW]    = m;
  endtask

  task automatic idleAll();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wem   = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    tick();
    RST = 1'b1;
    idleAll();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DW-1:0] rrData [4];
    logic [DW-1:0] colData [5];
    logic [3:0]    colReady [5];
    rrData   = '{8'h31, 8'h42, 8'h53, 8'h64};
    colData  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h14};
    colReady = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

    // Reset hold with every requester asking.
    idleAll();
    applyStimulus(0, 1'b1, 1'b1, 12'h001, 8'h11, 8'hFF);
    applyStimulus(1, 1'b1, 1'b0, 12'h002, 8'h00, 8'h00);
    applyStimulus(2, 1'b1, 1'b1, 12'h003, 8'h22, 8'hFF);
    applyStimulus(3, 1'b1, 1'b0, 12'h004, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checkOutput("hold_ready", 32'(req_ready), 32'h0);
      checkOutput("hold_ce0", 32'(sram_CE0), 32'h0);
      checkOutput("hold_ce1", 32'(sram_CE1), 32'h0);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    tick();
    RST = 1'b0;
    idleAll();

    // Basic write then read-back, plus a masked partial write.
    tick();
    applyStimulus(0, 1'b1, 1'b1, 12'h012, 8'hA5, 8'hFF);
    @(negedge CLK);
    checkOutput("wr_ready", 32'(req_ready), 32'b0001);
    checkOutput("wr_ce0", 32'(sram_CE0), 32'h1);
    checkOutput("wr_we0", 32'(sram_WE0), 32'h1);
    checkOutput("wr_a0", 32'(sram_A0), 32'h012);
    checkOutput("wr_d0", 32'(sram_D0), 32'hA5);
    checkOutput("wr_wem0", 32'(sram_WEM0), 32'hFF);
    checkOutput("wr_ce1", 32'(sram_CE1), 32'h0);
    checkOutput("wr_a1_idle", 32'(sram_A1), 32'h0);
    tick();
    idleAll();
    @(negedge CLK);
    checkOutput("idle_ce0", 32'(sram_CE0), 32'h0);
    checkOutput("idle_a0", 32'(sram_A0), 32'h0);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 12'h012, 8'h00, 8'h00);
    expQ.push_back('{2'd1, 8'hA5});
    @(negedge CLK);
    checkOutput("rd_ready", 32'(req_ready), 32'b0010);
    checkOutput("rd_ce1", 32'(sram_CE1), 32'h1);
    checkOutput("rd_a1", 32'(sram_A1), 32'h012);
    tick();
    idleAll();
    applyStimulus(2, 1'b1, 1'b1, 12'h012, 8'h00, 8'h0F);
    @(negedge CLK);
    checkOutput("mask_ready", 32'(req_ready), 32'b0100);
    checkOutput("mask_wem0", 32'(sram_WEM0), 32'h0F);
    tick();
    idleAll();
    applyStimulus(3, 1'b1, 1'b0, 12'h012, 8'h00, 8'h00);
    expQ.push_back('{2'd3, 8'hA0});
    @(negedge CLK);
    checkOutput("mask_rd_ready", 32'(req_ready), 32'b1000);
    tick();
    idleAll();
    @(negedge CLK);

    // Round robin over four continuous readers.
    resetDut();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0)
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b0, 12'h031 + 12'(i) * 12'h011, 8'h00, 8'h00);
      expQ.push_back('{2'(k % 4), rrData[k % 4]});
      @(negedge CLK);
      checkOutput($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1) << (k % 4));
    end
    tick();
    idleAll();
    @(negedge CLK);

    // Parallel write and read to different addresses.
    resetDut();
    tick();
    applyStimulus(0, 1'b1, 1'b1, 12'h100, 8'h3C, 8'hFF);
    applyStimulus(2, 1'b1, 1'b0, 12'h200, 8'h00, 8'h00);
    expQ.push_back('{2'd2, 8'h00});
    @(negedge CLK);
    checkOutput("par_ready", 32'(req_ready), 32'b0101);
    checkOutput("par_ce0", 32'(sram_CE0), 32'h1);
    checkOutput("par_ce1", 32'(sram_CE1), 32'h1);
    checkOutput("par_a0", 32'(sram_A0), 32'h100);
    checkOutput("par_a1", 32'(sram_A1), 32'h200);
    tick();
    idleAll();
    @(negedge CLK);

    // Same-address collision and the starvation guard.
    resetDut();
    for (int k = 0; k < 5; k++) begin
      tick();
      applyStimulus(0, 1'b1, 1'b1, 12'h055, colData[k], 8'hFF);
      applyStimulus(1, 1'b1, 1'b0, 12'h055, 8'h00, 8'h00);
      if (k == 3) expQ.push_back('{2'd1, 8'h13});
      @(negedge CLK);
      checkOutput($sformatf("col_ready_%0d", k), 32'(req_ready), 32'(colReady[k]));
      checkOutput($sformatf("col_ce0_%0d", k), 32'(sram_CE0), 32'(colReady[k][0]));
      checkOutput($sformatf("col_ce1_%0d", k), 32'(sram_CE1), 32'(colReady[k][1]));
    end
    tick();
    idleAll();
    @(negedge CLK);

    // Reset arriving while a read is requested; pointers must restart at 0.
    resetDut();
    tick();
    applyStimulus(2, 1'b1, 1'b1, 12'h0AA, 8'h77, 8'hFF);
    applyStimulus(1, 1'b1, 1'b0, 12'h031, 8'h00, 8'h00);
    expQ.push_back('{2'd1, 8'h31});
    @(negedge CLK);
    checkOutput("pre_rst_ready", 32'(req_ready), 32'b0110);
    tick();
    idleAll();
    RST = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 12'h042, 8'h00, 8'h00);
    @(negedge CLK);
    checkOutput("rst_rd_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rd_ce1", 32'(sram_CE1), 32'h0);
    tick();
    RST = 1'b0;
    idleAll();
    applyStimulus(0, 1'b1, 1'b0, 12'h031, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 1'b1, 12'h0A1, 8'h01, 8'hFF);
    applyStimulus(2, 1'b1, 1'b0, 12'h053, 8'h00, 8'h00);
    applyStimulus(3, 1'b1, 1'b1, 12'h0A3, 8'h03, 8'hFF);
    expQ.push_back('{2'd0, 8'h31});
    @(negedge CLK);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("post_rst_ready", 32'(req_ready), 32'b0011);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00);
    expQ.push_back('{2'd2, 8'h53});
    @(negedge CLK);
    checkOutput("post_rst_ready2", 32'(req_ready), 32'b1100);
    tick();
    idleAll();
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
